// File: rtl/best_price_scan_pkg.sv
// ============================================================================
// Module   : best_price_scan_pkg
// Brief    : Order word layout, slot encodings, book sides and scan states
//            shared by the book writer and the best-price reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package best_price_scan_pkg;

   localparam int ORDER_W   = 48;
   localparam int FIELD_W   = 16;
   localparam int ID_LSB    = 32;
   localparam int SIZE_LSB  = 16;
   localparam int LIMIT_LSB = 0;

   localparam logic [ORDER_W-1:0] SLOT_EMPTY   = 48'h0000_0000_0000;
   localparam logic [ORDER_W-1:0] SLOT_DELETED = 48'hFFFF_FFFF_FFFF;

   localparam logic SIDE_BUY  = 1'b0;
   localparam logic SIDE_SELL = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/best_price_scan_if.sv
// ============================================================================
// Module   : best_price_scan_if
// Brief    : Request, RAM read port and result bundle of the best-price
//            scanner. live_count exists only when SCAN_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface best_price_scan_if #(
   parameter int ADDR_W = 12
);
   import best_price_scan_pkg::*;

   logic                start;
   logic                side;
   logic [ADDR_W-1:0]   rd_addr;
   logic [ORDER_W-1:0]  rd_data;
   logic                found;
   logic [FIELD_W-1:0]  best_id;
   logic [FIELD_W-1:0]  best_size;
   logic [FIELD_W-1:0]  best_limit;
   logic [ADDR_W-1:0]   best_index;
   logic                done;
`ifdef SCAN_COUNT_EN
   logic [ADDR_W:0]     live_count;
`endif

   modport slave (
      input  start, side, rd_data,
      output rd_addr, found, best_id, best_size, best_limit, best_index, done
`ifdef SCAN_COUNT_EN
      , output live_count
`endif
   );

   modport master (
      output start, side, rd_data,
      input  rd_addr, found, best_id, best_size, best_limit, best_index, done
`ifdef SCAN_COUNT_EN
      , input live_count
`endif
   );

endinterface

`default_nettype wire

// File: rtl/best_price_scan_order_slot_decode.sv
// ============================================================================
// Module   : order_slot_decode
// Brief    : Splits a 48-bit order word into id/size/limit and flags whether
//            the slot holds a live order (neither empty nor deleted).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module order_slot_decode
   import best_price_scan_pkg::*;
(
   input  wire logic [ORDER_W-1:0] i_word,
   output logic                    o_live,
   output logic [FIELD_W-1:0]      o_id,
   output logic [FIELD_W-1:0]      o_size,
   output logic [FIELD_W-1:0]      o_limit
);

   assign o_live  = (i_word != SLOT_EMPTY) && (i_word != SLOT_DELETED);
   assign o_id    = i_word[ID_LSB    +: FIELD_W];
   assign o_size  = i_word[SIZE_LSB  +: FIELD_W];
   assign o_limit = i_word[LIMIT_LSB +: FIELD_W];

endmodule

`default_nettype wire

// File: rtl/best_price_scan.sv
// ============================================================================
// Module   : best_price_scan
// Brief    : Scans one side of the order book and returns the top-of-book
//            entry (highest buy limit / lowest sell limit, lowest index wins
//            ties). Define SCAN_COUNT_EN to add the live_count output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module best_price_scan
   import best_price_scan_pkg::*;
#(
   parameter int BOOK_SIZE = 10,
   parameter int ADDR_W    = 12
)(
   input  wire logic          clk,
   input  wire logic          rst,
   best_price_scan_if.slave   bus
);

   localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(BOOK_SIZE - 1);

   state_t              r_state;
   logic                r_side;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic                r_found;
   logic [FIELD_W-1:0]  r_best_id;
   logic [FIELD_W-1:0]  r_best_size;
   logic [FIELD_W-1:0]  r_best_limit;
   logic [ADDR_W-1:0]   r_best_index;
   logic                r_done;
   logic [ADDR_W:0]     r_live_count;

   logic                w_live;
   logic [FIELD_W-1:0]  w_id;
   logic [FIELD_W-1:0]  w_size;
   logic [FIELD_W-1:0]  w_limit;
   logic                w_replace;

   order_slot_decode u_decode (
      .i_word  (bus.rd_data),
      .o_live  (w_live),
      .o_id    (w_id),
      .o_size  (w_size),
      .o_limit (w_limit)
   );

   // Strict compares: an equal limit never displaces the earlier slot.
   assign w_replace = w_live && (!r_found
                      || ((r_side == SIDE_BUY)  && (w_limit > r_best_limit))
                      || ((r_side == SIDE_SELL) && (w_limit < r_best_limit)));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_side       <= SIDE_BUY;
         r_rd_addr    <= '0;
         r_found      <= 1'b0;
         r_best_id    <= '0;
         r_best_size  <= '0;
         r_best_limit <= '0;
         r_best_index <= '0;
         r_done       <= 1'b0;
         r_live_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_side       <= bus.side;
                  r_rd_addr    <= '0;
                  r_found      <= 1'b0;
                  r_best_id    <= '0;
                  r_best_size  <= '0;
                  r_best_limit <= '0;
                  r_best_index <= '0;
                  r_live_count <= '0;
                  r_state      <= ST_READ;
               end
            end
            ST_READ: begin
               r_state <= ST_CHECK;
            end
            ST_CHECK: begin
               if (w_replace) begin
                  r_found      <= 1'b1;
                  r_best_id    <= w_id;
                  r_best_size  <= w_size;
                  r_best_limit <= w_limit;
                  r_best_index <= r_rd_addr;
               end
               if (w_live) begin
                  r_live_count <= r_live_count + 1'b1;
               end
               if (r_rd_addr == c_LAST_ADDR) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_rd_addr <= r_rd_addr + 1'b1;
                  r_state   <= ST_READ;
               end
            end
            ST_DONE: begin
               if (!bus.start) begin
                  r_done  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.rd_addr    = r_rd_addr;
   assign bus.found      = r_found;
   assign bus.best_id    = r_best_id;
   assign bus.best_size  = r_best_size;
   assign bus.best_limit = r_best_limit;
   assign bus.best_index = r_best_index;
   assign bus.done       = r_done;

`ifdef SCAN_COUNT_EN
   assign bus.live_count = r_live_count;
`else
   logic w_unused_count;
   assign w_unused_count = ^r_live_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_best_price_scan.sv
// ============================================================================
// Module   : tb_best_price_scan
// Brief    : Self-checking bench for best_price_scan: directed book table,
//            randomized books against a reference model, hold/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_best_price_scan;
   import best_price_scan_pkg::*;

   localparam int N  = 10;
   localparam int AW = 12;

   typedef struct packed {
      logic                side;
      logic [N-1:0][47:0]  w;
      logic                f;
      logic [15:0]         id;
      logic [15:0]         size;
      logic [15:0]         lim;
      logic [AW-1:0]       idx;
      logic [AW:0]         cnt;
   } vec_t;

   logic clk;
   logic rst;
   logic [47:0] mem [N];
   int n_cmp;
   int n_bad;

   best_price_scan_if #(.ADDR_W(AW)) bus ();

   best_price_scan #(.BOOK_SIZE(N), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read book RAM: data for rd_addr appears one edge later.
   always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

   function automatic logic [47:0] mk(input logic [15:0] id, input logic [15:0] sz,
                                      input logic [15:0] lim);
      return {id, sz, lim};
   endfunction

   function automatic bit is_live(input logic [47:0] w);
      return (w != 48'h0) && (w != 48'hFFFF_FFFF_FFFF);
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Extremum limit over live slots first, then earliest slot carrying it.
   task automatic ref_scan(input bit sd, output vec_t r);
      int best;
      best = -1;
      r = '0;
      r.side = sd;
      for (int i = 0; i < N; i++) begin
         if (is_live(mem[i])) begin
            r.cnt++;
            if (best < 0) best = int'(mem[i][15:0]);
            else if (sd == 1'b0 && int'(mem[i][15:0]) > best) best = int'(mem[i][15:0]);
            else if (sd == 1'b1 && int'(mem[i][15:0]) < best) best = int'(mem[i][15:0]);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (best >= 0 && is_live(mem[i]) && int'(mem[i][15:0]) == best) begin
            r.f    = 1'b1;
            r.id   = mem[i][47:32];
            r.size = mem[i][31:16];
            r.lim  = mem[i][15:0];
            r.idx  = AW'(i);
            break;
         end
      end
   endtask

   task automatic do_scan(input bit sd, input string tag);
      int lat;
      @(negedge clk);
      bus.side  = sd;
      bus.start = 1'b1;
      @(posedge clk);
      lat = 0;
      while (lat < 200) begin
         @(posedge clk);
         lat++;
         #1;
         if (bus.done) break;
      end
      cmp({tag, ".latency"}, 64'(lat), 64'(2 * N));
   endtask

   task automatic check_res(input string tag, input vec_t e);
      cmp({tag, ".done"},  64'(bus.done), 64'd1);
      cmp({tag, ".found"}, 64'(bus.found), 64'(e.f));
      cmp({tag, ".id"},    64'(bus.best_id), 64'(e.id));
      cmp({tag, ".size"},  64'(bus.best_size), 64'(e.size));
      cmp({tag, ".limit"}, 64'(bus.best_limit), 64'(e.lim));
      cmp({tag, ".index"}, 64'(bus.best_index), 64'(e.idx));
`ifdef SCAN_COUNT_EN
      cmp({tag, ".count"}, 64'(bus.live_count), 64'(e.cnt));
`endif
   endtask

   task automatic release_start(input string tag);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      cmp({tag, ".done_clr"}, 64'(bus.done), 64'd0);
   endtask

   vec_t vt [6];
   vec_t e;
   vec_t hold_ref;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.side  = 1'b0;
      for (int i = 0; i < N; i++) mem[i] = '0;

      for (int k = 0; k < 6; k++) vt[k] = '0;
      vt[0].side = 1'b0;
      vt[0].w[0] = mk(16'h0A01, 16'd5, 16'd100);
      vt[0].w[3] = mk(16'h0A03, 16'd7, 16'd250);
      vt[0].w[7] = mk(16'h0A07, 16'd9, 16'd180);
      vt[0].f = 1'b1; vt[0].id = 16'h0A03; vt[0].size = 16'd7; vt[0].lim = 16'd250;
      vt[0].idx = 12'd3; vt[0].cnt = 13'd3;

      vt[1].side = 1'b1;
      vt[1].w[2] = mk(16'h0B02, 16'd1, 16'd300);
      vt[1].w[5] = mk(16'h0B05, 16'd2, 16'd120);
      vt[1].w[9] = mk(16'h0B09, 16'd3, 16'd120);
      vt[1].f = 1'b1; vt[1].id = 16'h0B05; vt[1].size = 16'd2; vt[1].lim = 16'd120;
      vt[1].idx = 12'd5; vt[1].cnt = 13'd3;

      vt[2].side = 1'b0;
      for (int i = 1; i < N; i += 2) vt[2].w[i] = 48'hFFFF_FFFF_FFFF;

      vt[3].side = 1'b0;
      vt[3].w[4] = 48'hFFFF_FFFF_FFFF;
      vt[3].w[6] = mk(16'h0C06, 16'd4, 16'd10);
      vt[3].f = 1'b1; vt[3].id = 16'h0C06; vt[3].size = 16'd4; vt[3].lim = 16'd10;
      vt[3].idx = 12'd6; vt[3].cnt = 13'd1;

      vt[4].side = 1'b1;
      vt[4].w[1] = mk(16'h0002, 16'd3, 16'd50);
      vt[4].w[8] = mk(16'h0001, 16'd0, 16'd0);
      vt[4].f = 1'b1; vt[4].id = 16'h0001; vt[4].size = 16'd0; vt[4].lim = 16'd0;
      vt[4].idx = 12'd8; vt[4].cnt = 13'd2;

      vt[5].side = 1'b0;
      vt[5].w[0] = mk(16'h0D00, 16'd1, 16'd5);
      vt[5].w[9] = mk(16'h0D09, 16'd1, 16'hFFFF);
      vt[5].f = 1'b1; vt[5].id = 16'h0D09; vt[5].size = 16'd1; vt[5].lim = 16'hFFFF;
      vt[5].idx = 12'd9; vt[5].cnt = 13'd2;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cmp("reset.rd_addr", 64'(bus.rd_addr), 64'd0);
      cmp("reset.found",   64'(bus.found), 64'd0);
      cmp("reset.done",    64'(bus.done), 64'd0);
      cmp("reset.best",    64'({bus.best_id, bus.best_size, bus.best_limit}), 64'd0);
      cmp("reset.index",   64'(bus.best_index), 64'd0);

      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) mem[i] = vt[k].w[i];
         do_scan(vt[k].side, $sformatf("vec%0d", k));
         check_res($sformatf("vec%0d", k), vt[k]);
         release_start($sformatf("vec%0d", k));
      end

      // Hold start after done, then rescan the same book from the other side.
      @(negedge clk);
      for (int i = 0; i < N; i++) mem[i] = mk(16'(100 + i), 16'(i), 16'(i * 37 % 11));
      ref_scan(1'b0, hold_ref);
      do_scan(1'b0, "hold");
      @(negedge clk);
      bus.side = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_res("hold", hold_ref);
      release_start("hold");
      ref_scan(1'b1, e);
      do_scan(1'b1, "hold_sell");
      check_res("hold_sell", e);
      release_start("hold_sell");

      // Reset in the middle of a scan, then a complete scan afterwards.
      @(negedge clk);
      for (int i = 0; i < N; i++) mem[i] = vt[0].w[i];
      bus.side  = 1'b0;
      bus.start = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      cmp("midrst.rd_addr", 64'(bus.rd_addr), 64'd0);
      cmp("midrst.done",    64'(bus.done), 64'd0);
      cmp("midrst.found",   64'(bus.found), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      do_scan(1'b0, "post_rst");
      check_res("post_rst", vt[0]);
      release_start("post_rst");

      for (int t = 0; t < 25; t++) begin
         bit sd;
         @(negedge clk);
         sd = 1'($urandom_range(0, 1));
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
               0:       mem[i] = 48'h0;
               1:       mem[i] = 48'hFFFF_FFFF_FFFF;
               default: mem[i] = mk(16'($urandom_range(1, 65534)), 16'($urandom),
                                    16'($urandom_range(0, 6)));
            endcase
         end
         ref_scan(sd, e);
         do_scan(sd, $sformatf("rnd%0d", t));
         check_res($sformatf("rnd%0d", t), e);
         release_start($sformatf("rnd%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/best_price_scan.md
Name: best_price_scan

Overview:
- Reader counterpart to the order-insert writer. On request, scans one side of the book (buy or sell order RAM) and returns the top-of-book entry.
  - Buy side: highest limit.
  - Sell side: lowest limit.
- Sits between the book RAMs' read port (muxed externally per side) and the matching/quote logic.
- Uses the same 48-bit order word layout and the same empty/deleted slot encoding as the writer.

Parameters:
- BOOK_SIZE, 10, number of slots scanned (legal range 1..4096).
- ADDR_W, 12, RAM address width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  level request; sampled only in IDLE
- side  in  1  0 = buy book, 1 = sell book; latched on start acceptance
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  48  RAM read data, valid one cycle after rd_addr
- found  out  1  at least one live order seen
- best_id  out  16  id of best order
- best_size  out  16  size of best order
- best_limit  out  16  limit of best order
- best_index  out  ADDR_W  slot index of best order
- done  out  1  scan complete; held until start deasserts

Behaviour:
- Order word fields: [47:32] id, [31:16] size, [15:0] limit.
- A slot is live iff the word is neither 48'h0 (empty) nor 48'hFFFF_FFFF_FFFF (deleted). Size 0 and limit 0 are legal in a live word.
- Reset (sync, active-high): state IDLE; rd_addr=0; found=0; best_id/size/limit=0; best_index=0; done=0.
- States: IDLE, READ, CHECK, DONE.
- IDLE:
  - If start=1: latch side; clear found and all best_* outputs; rd_addr=0; go to READ.
  - Otherwise stay in IDLE.
- READ: rd_addr stable; go to CHECK. rd_data is valid in CHECK.
- CHECK: if the slot is live, it replaces the current best when any of these holds:
  - found=0;
  - buy side and limit > best_limit (unsigned);
  - sell side and limit < best_limit (unsigned).
  - On replacement: set found=1 and load id/size/limit/index.
  - Ties keep the lower index (strict compare).
  - If rd_addr == BOOK_SIZE-1: go to DONE and set done=1. Else rd_addr+1, go to READ.
- DONE:
  - done=1; outputs frozen.
  - If start=0: go to IDLE, done=0. Else stay in DONE.
- Latency: done rises 2*BOOK_SIZE clock edges after the edge that samples start in IDLE (20 cycles at default).
- No live slot: found=0 and best_* remain 0.
- start toggling during READ/CHECK: ignored. side changes mid-scan: ignored (latched value used).
- rd_addr never exceeds BOOK_SIZE-1; no wrap.
- rst asserted mid-scan: immediate return to reset values next edge; no partial result is presented.
- best_* are valid only while done=1. They hold their value until the next start is accepted.

Optional Feature:
- Macro: SCAN_COUNT_EN.
- Defined: adds output live_count [ADDR_W:0], the number of live slots scanned.
  - Cleared on start acceptance; incremented in CHECK per live slot.
  - Valid with done; reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package (common with the writer):
  - ORDER_W=48;
  - field offsets/widths for id, size, limit;
  - SLOT_EMPTY=48'h0 and SLOT_DELETED=48'hFFFF_FFFF_FFFF;
  - SIDE_BUY=0 and SIDE_SELL=1;
  - state encoding constants.
- One combinational sub-module, order_slot_decode: word in → live flag, id, size, limit out. The writer can reuse it.

Test Plan:
- Buy book with limits {0:100, 3:250, 7:180}, other slots empty, side=0 → done after 20 cycles; found=1, best_limit=250, best_index=3, id/size match slot 3.
- Sell book with limits {2:300, 5:120, 9:120}, side=1 → best_limit=120, best_index=5 (tie keeps lower index).
- All slots 0 or all-ones → found=0, best_* all 0, done=1. With SCAN_COUNT_EN, live_count=0.
- Slot 4 set to all-ones with limit field 65535, slot 6 live at 10, side=0 → best_index=6 (deleted slot skipped).
- Hold start=1 after done → done stays 1 and outputs stable; drop start → IDLE next edge with done=0. Reassert start with the other side → fresh result.
- Assert rst at cycle 9 of a scan → next edge: rd_addr=0, done=0, found=0. A new start then completes a full 20-cycle scan.
